// File: rtl/halt_drain_unit_pkg.sv
// ------------------------------------------------------------------
// halt_drain_unit_pkg : shared pipeline types and opcode constants
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package halt_drain_unit_pkg;

  typedef enum logic [1:0] {
    HD_RUN    = 2'd0,
    HD_DRAIN  = 2'd1,
    HD_HALTED = 2'd2
  } hd_state_t;

  // Shared with the decoder so both agree on the HALT encoding
  localparam logic [6:0] OPC_HALT = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/halt_drain_unit_if.sv
// ------------------------------------------------------------------
// halt_drain_unit_if : pipeline control bundle between ID/EX and the halt unit
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface halt_drain_unit_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_halt;
  logic             ex_branch_taken;
  logic             resume;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             draining;
  logic             halted;
  logic [CNT_W-1:0] halt_cycles;

  modport master (
    output id_valid, id_halt, ex_branch_taken, resume,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           draining, halted, halt_cycles
  );

  modport slave (
    input  id_valid, id_halt, ex_branch_taken, resume,
    output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
           draining, halted, halt_cycles
  );
endinterface

`default_nettype wire

// File: rtl/halt_drain_unit_sat_counter.sv
// ------------------------------------------------------------------
// sat_counter : up-counter with synchronous clear that sticks at all-ones
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  wire          clk,
  input  wire          reset_n,
  input  wire          clear,
  input  wire          enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/halt_drain_unit.sv
// ------------------------------------------------------------------
// halt_drain_unit : freezes fetch on HALT in ID, drains EX/MEM/WB, reports halted
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module halt_drain_unit
  import halt_drain_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  wire               clk,
  input  wire               reset_n,
  halt_drain_unit_if.slave  bus
);

  localparam int             DCW        = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_CYCLES - 1);

  hd_state_t      state;
  hd_state_t      state_nxt;
  logic [DCW-1:0] drain_cnt;
  logic [DCW-1:0] drain_nxt;
  logic           detect;
  logic           enter_halted;

  // Gating with reset_n keeps the Mealy outputs quiet while reset is held
  assign detect       = reset_n & bus.id_valid & bus.id_halt & ~bus.ex_branch_taken;
  assign enter_halted = (state == HD_DRAIN) && (drain_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HD_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    case (state)
      HD_RUN: begin
        if (detect) begin
          state_nxt = HD_DRAIN;
          drain_nxt = DRAIN_INIT;
        end
      end
      HD_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = HD_HALTED;
        end else begin
          drain_nxt = drain_cnt - DCW'(1);
        end
      end
      HD_HALTED: begin
        if (bus.resume) begin
          state_nxt = HD_RUN;
        end
      end
      default: begin
        state_nxt = HD_RUN;
        drain_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus.pc_stall     = 1'b0;
    bus.if_id_stall  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.draining     = 1'b0;
    bus.halted       = 1'b0;
    case (state)
      HD_RUN: begin
        if (detect) begin
          bus.pc_stall     = 1'b1;
          bus.if_id_stall  = 1'b1;
          bus.id_ex_bubble = 1'b1;
        end
      end
      HD_DRAIN: begin
        bus.pc_stall     = 1'b1;
        bus.if_id_stall  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bus.draining     = 1'b1;
      end
      HD_HALTED: begin
        bus.halted       = 1'b1;
        bus.id_ex_bubble = 1'b1;
        // Resume releases fetch and discards the HALT word still sitting in IF/ID
        if (bus.resume) begin
          bus.if_id_flush = 1'b1;
        end else begin
          bus.pc_stall    = 1'b1;
          bus.if_id_stall = 1'b1;
        end
      end
      default: begin
        bus.pc_stall = 1'b0;
      end
    endcase
  end

  sat_counter #(
    .W (CNT_W)
  ) u_halt_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (enter_halted),
    .enable  (state == HD_HALTED),
    .count   (bus.halt_cycles)
  );

endmodule

`default_nettype wire

// File: tb/tb_halt_drain_unit.sv
// ------------------------------------------------------------------
// tb_halt_drain_unit : directed checks of halt detect, drain, resume and counter
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_halt_drain_unit;

  logic clk = 1'b0;
  logic reset_n;
  logic id_valid;
  logic id_halt;
  logic ex_branch_taken;
  logic resume;

  int total = 0;
  int bad   = 0;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, draining, halted}
  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_DETECT = 6'b110100;
  localparam logic [5:0] O_DRAIN  = 6'b110110;
  localparam logic [5:0] O_HALTED = 6'b110101;
  localparam logic [5:0] O_RESUME = 6'b001101;

  halt_drain_unit_if #(.CNT_W(32)) if_a ();
  halt_drain_unit_if #(.CNT_W(4))  if_b ();

  assign if_a.id_valid        = id_valid;
  assign if_a.id_halt         = id_halt;
  assign if_a.ex_branch_taken = ex_branch_taken;
  assign if_a.resume          = resume;
  assign if_b.id_valid        = id_valid;
  assign if_b.id_halt         = id_halt;
  assign if_b.ex_branch_taken = ex_branch_taken;
  assign if_b.resume          = resume;

  halt_drain_unit #(.DRAIN_CYCLES(3), .CNT_W(32)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_a)
  );

  halt_drain_unit #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if_b)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs_a();
    return {if_a.pc_stall, if_a.if_id_stall, if_a.if_id_flush,
            if_a.id_ex_bubble, if_a.draining, if_a.halted};
  endfunction

  function automatic logic [5:0] outs_b();
    return {if_b.pc_stall, if_b.if_id_stall, if_b.if_id_flush,
            if_b.id_ex_bubble, if_b.draining, if_b.halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled after the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic halt_detect();
    id_valid = 1'b1;
    id_halt  = 1'b1;
    #1;
    step();
    id_valid = 1'b0;
    id_halt  = 1'b0;
  endtask

  initial begin
    reset_n         = 1'b0;
    id_valid        = 1'b1;
    id_halt         = 1'b1;
    ex_branch_taken = 1'b0;
    resume          = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs_a()), 32'(O_IDLE));
    chk("reset_cnt", if_a.halt_cycles, 32'd0);
    id_valid = 1'b0;
    id_halt  = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("run_idle", 32'(outs_a()), 32'(O_IDLE));

    // 1: detect, three drain cycles, halted after the fourth edge
    id_valid = 1'b1;
    id_halt  = 1'b1;
    #1;
    chk("t1_detect", 32'(outs_a()), 32'(O_DETECT));
    step();
    id_valid = 1'b0;
    id_halt  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t1_drain%0d", i), 32'(outs_a()), 32'(O_DRAIN));
      step();
    end
    #1;
    chk("t1_halted", 32'(outs_a()), 32'(O_HALTED));
    chk("t1_cnt0", if_a.halt_cycles, 32'd0);

    // 3: ten halted cycles, then resume
    for (int i = 0; i < 10; i++) step();
    resume = 1'b1;
    #1;
    chk("t3_cnt10", if_a.halt_cycles, 32'd10);
    chk("t3_resume", 32'(outs_a()), 32'(O_RESUME));
    step();
    resume = 1'b0;
    #1;
    chk("t3_run", 32'(outs_a()), 32'(O_IDLE));

    // 2: taken branch squashes the halt
    id_valid        = 1'b1;
    id_halt         = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    chk("t2_squash", 32'(outs_a()), 32'(O_IDLE));
    step();
    id_valid        = 1'b0;
    id_halt         = 1'b0;
    ex_branch_taken = 1'b0;
    #1;
    chk("t2_still_run", 32'(outs_a()), 32'(O_IDLE));

    // 4: resume in RUN and through DRAIN is ignored
    resume = 1'b1;
    #1;
    chk("t4_run_resume", 32'(outs_a()), 32'(O_IDLE));
    step();
    resume = 1'b0;
    halt_detect();
    resume = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_drain%0d", i), 32'(outs_a()), 32'(O_DRAIN));
      step();
    end
    resume = 1'b0;
    #1;
    chk("t4_halted", 32'(outs_a()), 32'(O_HALTED));
    resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    chk("t4_back_run", 32'(outs_a()), 32'(O_IDLE));

    // 5: async reset in the middle of DRAIN
    halt_detect();
    #1;
    chk("t5_draining", 32'(outs_a()), 32'(O_DRAIN));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_outs", 32'(outs_a()), 32'(O_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t5_release", 32'(outs_a()), 32'(O_IDLE));
    step();
    #1;
    chk("t5_stay_run", 32'(outs_a()), 32'(O_IDLE));
    chk("t5_cnt_clr", if_a.halt_cycles, 32'd0);

    // 6: 4-bit counter saturates, then clears on the next halt entry
    halt_detect();
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("t6_halted_b", 32'(outs_b()), 32'(O_HALTED));
    for (int i = 0; i < 20; i++) step();
    #1;
    chk("t6_sat_b", 32'(if_b.halt_cycles), 32'h0000000F);
    chk("t6_wide_a", if_a.halt_cycles, 32'd20);
    resume = 1'b1;
    step();
    resume = 1'b0;
    halt_detect();
    for (int i = 0; i < 3; i++) step();
    #1;
    chk("t6_rehalt_b", 32'(outs_b()), 32'(O_HALTED));
    chk("t6_reclr_b", 32'(if_b.halt_cycles), 32'd0);
    resume = 1'b1;
    step();
    resume = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
